// File: rtl/sensor_sampler.sv
// Periodic SPI reader for a 12-bit serial ADC (16-clock frame). Averages
// 2^AVG_LOG2 samples, clamps the average to MAX_VALUE and holds the result.
module sensor_sampler #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter int unsigned AVG_LOG2      = 4,
  parameter int unsigned MAX_VALUE     = 9999
) (
  input  logic        fpga_clk1,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        busy,
  output logic        overrange
);

  localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CONVERT,
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [11:0]   shift;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [11:0]   avg;

  assign tick = (timer == TW'(SAMPLE_PERIOD - 1));
  assign avg  = 12'(acc >> AVG_LOG2);

  // Only 12 shift bits are kept: the 4 leading frame bits fall out the top.
  always_ff @(posedge fpga_clk1 or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      acc         <= '0;
      cnt         <= '0;
      adc_cs_n    <= 1'b1;
      adc_sclk    <= 1'b1;
      busy        <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
      overrange   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (state != ST_IDLE) timer <= tick ? '0 : timer + 1'b1;

      case (state)
        ST_IDLE: begin
          timer <= '0;
          acc   <= '0;
          cnt   <= '0;
          if (enable) state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
            timer <= '0;
            acc   <= '0;
            cnt   <= '0;
          end else if (tick) begin
            state    <= ST_CONVERT;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end

        ST_CONVERT: begin
          if (bit_cnt == 5'd16) begin
            state    <= ST_ACCUM;
            adc_cs_n <= 1'b1;
            busy     <= 1'b0;
            adc_sclk <= 1'b1;
          end else if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt  <= '0;
            adc_sclk <= ~adc_sclk;
            if (!adc_sclk) begin
              shift   <= {shift[10:0], adc_sdata};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_ACCUM: begin
          acc <= acc + AW'(shift);
          cnt <= cnt + 1'b1;
          if (cnt == CW'((1 << AVG_LOG2) - 1)) begin
            state <= ST_OUTPUT;
          end else if (!enable) begin
            state <= ST_IDLE;
            timer <= '0;
            acc   <= '0;
            cnt   <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_OUTPUT: begin
          if (32'(avg) > MAX_VALUE) begin
            value     <= 16'(MAX_VALUE);
            overrange <= 1'b1;
          end else begin
            value     <= 16'(avg);
            overrange <= 1'b0;
          end
          value_valid <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          if (enable) begin
            state <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
            timer <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_sampler.sv
// Bench for sensor_sampler: serial ADC model, frame-level reference model of
// averaging/clamping/enable behaviour, and scripted plus randomized scenarios.
module tb_sensor_sampler;

  localparam int unsigned CD   = 2;
  localparam int unsigned SP   = 100;
  localparam int unsigned AL   = 2;
  localparam int unsigned MV   = 4000;
  localparam int unsigned NAVG = 1 << AL;

  logic        fpga_clk1 = 1'b0;
  logic        reset     = 1'b0;
  logic        enable    = 1'b0;
  logic        adc_sdata = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [15:0] value;
  logic        value_valid;
  logic        busy;
  logic        overrange;

  always #5 fpga_clk1 = ~fpga_clk1;

  sensor_sampler #(
    .CLK_DIV      (CD),
    .SAMPLE_PERIOD(SP),
    .AVG_LOG2     (AL),
    .MAX_VALUE    (MV)
  ) dut (
    .fpga_clk1  (fpga_clk1),
    .reset      (reset),
    .enable     (enable),
    .adc_sdata  (adc_sdata),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .value      (value),
    .value_valid(value_valid),
    .busy       (busy),
    .overrange  (overrange)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [11:0] s;
    if ($urandom_range(0, 1) == 1) s = 12'($urandom_range(3800, 4095));
    else                           s = 12'($urandom_range(0, 4095));
    return {4'($urandom), s};
  endfunction

  // ADC model: one word per frame, bit 15-k presented after the k-th SCLK fall
  logic [15:0] adc_q[$];
  logic [15:0] cur_word = '0;
  int unsigned fall_idx = 0;
  int unsigned frames   = 0;
  int unsigned rises    = 0;

  always @(negedge adc_cs_n) begin
    frames++;
    rises    = 0;
    fall_idx = 0;
    if (adc_q.size() > 0) cur_word = adc_q.pop_front();
    else                  cur_word = rand_word();
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n && fall_idx < 16) begin
      adc_sdata = cur_word[15 - fall_idx];
      fall_idx++;
    end
  end

  always @(posedge adc_sclk) if (!adc_cs_n) rises++;

  // Reference model, evaluated once per cycle away from the active edge
  int unsigned cyc = 0, t = 0, last_fall = 0;
  int unsigned part_sum = 0, part_n = 0, pend = 0, avg_m = 0;
  bit          prev_cs = 1'b1, cont_en = 1'b0, have_fall = 1'b0;
  bit          exp_valid, exp_ovr = 1'b0, nxt_ovr = 1'b0;
  logic [15:0] exp_val = '0, nxt_val = '0;

  always @(negedge fpga_clk1) begin
    cyc++;
    if (!reset) begin
      part_sum = 0; part_n = 0; pend = 0;
      exp_val = '0; exp_ovr = 1'b0;
      prev_cs = 1'b1; cont_en = 1'b0; have_fall = 1'b0;
      check("rst_cs_n", adc_cs_n, 1);
      check("rst_sclk", adc_sclk, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", value_valid, 0);
      check("rst_value", value, 0);
      check("rst_ovr", overrange, 0);
    end else begin
      exp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          exp_valid = 1'b1;
          exp_val   = nxt_val;
          exp_ovr   = nxt_ovr;
        end
      end
      if (!adc_cs_n) begin
        if (prev_cs) begin
          t = 0;
          if (have_fall && cont_en) check("frame_spacing", cyc - last_fall, SP);
          last_fall = cyc; have_fall = 1'b1; cont_en = 1'b1;
        end else begin
          t++;
        end
        check("sclk_in_frame", adc_sclk, ((t / CD) % 2 == 0) ? 1 : 0);
      end else begin
        check("sclk_idle", adc_sclk, 1);
        if (!prev_cs) begin
          check("cs_low_len", t + 1, 32 * CD + 1);
          part_sum += cur_word[11:0];
          part_n++;
          if (part_n == NAVG) begin
            avg_m = part_sum / NAVG;
            if (avg_m > MV) begin nxt_val = 16'(MV);    nxt_ovr = 1'b1; end
            else            begin nxt_val = 16'(avg_m); nxt_ovr = 1'b0; end
            pend = 2;
            part_sum = 0; part_n = 0;
          end
        end
        if (!enable) begin part_sum = 0; part_n = 0; end
      end
      if (!enable) cont_en = 1'b0;
      check("busy", busy, !adc_cs_n);
      check("value_valid", value_valid, exp_valid);
      check("value", value, exp_val);
      check("overrange", overrange, exp_ovr);
      prev_cs = adc_cs_n;
    end
  end

  task automatic set_en(input logic v);
    @(posedge fpga_clk1);
    #1 enable = v;
  endtask

  task automatic wait_valid();
    int unsigned k = 0;
    do begin
      @(negedge fpga_clk1);
      k++;
    end while (value_valid !== 1'b1 && k < 2000);
    check("valid_wait", value_valid, 1);
  endtask

  task automatic wait_frames(input int unsigned n);
    int unsigned k = 0;
    while (frames < n && k < 1000) begin
      @(negedge fpga_clk1);
      k++;
    end
    check("frame_wait", (frames >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_rises(input int unsigned n);
    int unsigned k = 0;
    while (rises < n && k < 200) begin
      @(negedge fpga_clk1);
      k++;
    end
    check("rise_wait", (rises >= n) ? 1 : 0, 1);
  endtask

  task automatic go_idle();
    int unsigned k = 0;
    set_en(1'b0);
    while (busy !== 1'b0 && k < 200) begin
      @(negedge fpga_clk1);
      k++;
    end
    check("idle_wait", busy, 0);
    repeat (5) @(posedge fpga_clk1);
  endtask

  int unsigned f0;

  initial begin
    // Reset and idle with enable low
    repeat (5) @(posedge fpga_clk1);
    #2 reset = 1'b1;
    repeat (2) @(negedge fpga_clk1);
    check("t1_cs_n", adc_cs_n, 1);
    check("t1_sclk", adc_sclk, 1);
    check("t1_value", value, 0);
    check("t1_busy", busy, 0);
    repeat (300) @(negedge fpga_clk1);
    check("t1_no_frames", frames, 0);

    // Fixed word 0x0ABC
    repeat (NAVG) adc_q.push_back(16'h0ABC);
    f0 = frames;
    set_en(1'b1);
    wait_valid();
    check("t2_value", value, 2748);
    check("t2_ovr", overrange, 0);
    check("t2_rises", rises, 16);
    check("t2_frames", frames - f0, NAVG);

    // Averaging with truncation; leading nibble must be ignored
    go_idle();
    for (int i = 0; i < 4; i++) adc_q.push_back({4'($urandom), 12'(100 + i)});
    set_en(1'b1);
    wait_valid();
    check("t3_value", value, 101);

    // Clamp, then recover
    go_idle();
    repeat (NAVG) adc_q.push_back(16'h0FFF);
    repeat (NAVG) adc_q.push_back(16'hF00A);
    set_en(1'b1);
    wait_valid();
    check("t4_clamp_value", value, 4000);
    check("t4_clamp_ovr", overrange, 1);
    wait_valid();
    check("t4_low_value", value, 10);
    check("t4_low_ovr", overrange, 0);

    // Enable drop mid-frame discards the partial set
    go_idle();
    adc_q.push_back(16'd50);
    adc_q.push_back(16'd60);
    adc_q.push_back(16'd70);
    f0 = frames;
    set_en(1'b1);
    wait_frames(f0 + 3);
    wait_rises(7);
    set_en(1'b0);
    repeat (300) @(negedge fpga_clk1);
    check("t5_no_4th_frame", frames - f0, 3);
    repeat (NAVG) adc_q.push_back(16'd8);
    set_en(1'b1);
    wait_valid();
    check("t5_value", value, 8);

    // Asynchronous reset in the middle of a frame
    go_idle();
    adc_q.push_back(16'h0ABC);
    repeat (NAVG) adc_q.push_back({4'($urandom), 12'h5A5});
    f0 = frames;
    set_en(1'b1);
    wait_frames(f0 + 1);
    wait_rises(9);
    #2 reset = 1'b0;
    #1;
    check("t6_cs_n_async", adc_cs_n, 1);
    check("t6_sclk_async", adc_sclk, 1);
    check("t6_value_async", value, 0);
    check("t6_busy_async", busy, 0);
    repeat (3) @(negedge fpga_clk1);
    #2 reset = 1'b1;
    wait_valid();
    check("t6_value", value, 1445);

    // Randomized samples and enable toggling
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(50, 400)) @(posedge fpga_clk1);
      if ($urandom_range(0, 3) == 0) begin
        set_en(1'b0);
        repeat ($urandom_range(1, 150)) @(posedge fpga_clk1);
        set_en(1'b1);
      end
    end
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_sampler.md
Name: sensor_sampler

Overview:
- Upstream stage of the sensor display path. Runs a periodic SPI read of a 12-bit serial ADC (ADCS7476-class, 16-clock frame).
- Averages 2^AVG_LOG2 samples and clamps the result to the 4-digit display range.
- Presents a held 16-bit value, which the SensorController top consumes on its value input.

Parameters:
- CLK_DIV, 25: fpga_clk1 cycles per SCLK half-period (100 MHz gives 2 MHz SCLK); must be >= 1.
- SAMPLE_PERIOD, 100000: fpga_clk1 cycles between frame starts; must be >= 32*CLK_DIV+4.
- AVG_LOG2, 4: log2 of the number of samples averaged per output; 0 to 4.
- MAX_VALUE, 9999: clamp ceiling for value.

Ports:
- fpga_clk1  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = sample periodically; 0 = stop after the current frame.
- adc_sdata  in  1  ADC serial data, MSB first.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, idles high.
- value  out  16  averaged, clamped sample, zero-extended; held between updates.
- value_valid  out  1  one-cycle pulse when value updates.
- busy  out  1  high while adc_cs_n is low.
- overrange  out  1  high if the last update was clamped; held.

Behaviour:
- Reset (reset=0, asynchronous):
  - adc_cs_n=1, adc_sclk=1, busy=0.
  - value=0, value_valid=0, overrange=0.
  - Timer, bit counter, accumulator and sample count all cleared; FSM goes to IDLE.
  - Applies immediately, including mid-frame.
- FSM states: IDLE, WAIT, CONVERT, ACCUM, OUTPUT.
- IDLE:
  - Accumulator and sample count held at 0; timer held at 0.
  - enable=1 goes to WAIT.
- WAIT:
  - Timer counts 0..SAMPLE_PERIOD-1; the frame starts at terminal count and the timer wraps.
  - enable=0 goes to IDLE; the partial average is discarded and value is held.
- Frame timing (CONVERT), with t=0 the cycle adc_cs_n goes low:
  - busy rises with adc_cs_n.
  - adc_sclk toggles every CLK_DIV cycles: first fall at t=CLK_DIV, k-th rise at t=2k*CLK_DIV, k=1..16.
  - adc_sdata is registered into the shift register in the cycle adc_sclk is driven high.
  - adc_cs_n and busy return high at t=32*CLK_DIV+1; adc_sclk remains high.
- Sample data: the sample is shift[11:0]; the 4 leading bits are ignored.
- ACCUM (1 cycle):
  - Accumulator (12+AVG_LOG2 bits, no overflow possible) += sample; count += 1.
  - If count reaches 2^AVG_LOG2, go to OUTPUT; else go to WAIT, or to IDLE if enable=0.
- OUTPUT (1 cycle):
  - avg = acc >> AVG_LOG2 (truncating).
  - If avg > MAX_VALUE: value=MAX_VALUE, overrange=1. Else value=avg, overrange=0.
  - value_valid=1 for this cycle only; acc and count cleared.
  - Next state is WAIT, or IDLE if enable=0.
- Timer runs throughout WAIT/CONVERT/ACCUM/OUTPUT; frame-start ticks are spaced exactly SAMPLE_PERIOD cycles.
- A tick arriving while not in WAIT is dropped; the parameter constraint makes this unreachable.
- enable falling mid-frame does not abort the frame: the frame completes and is accumulated (and output if it completes the set); then the FSM goes to IDLE and the partial accumulator is cleared.
- AVG_LOG2=0: every frame produces an output.
- Output latency: value_valid asserts 2 cycles after adc_cs_n rises on the completing frame.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset: hold reset=0, then release with enable=0 -> adc_cs_n=1, adc_sclk=1, value=0, value_valid=0, busy=0, no frames issued.
2. Single frame: CLK_DIV=2, AVG_LOG2=0, SAMPLE_PERIOD=100, ADC model returns 0x0ABC -> adc_cs_n low 65 cycles, 16 SCLK rises, value=2748, one valid pulse; frame starts 100 cycles apart.
3. Averaging: AVG_LOG2=2, samples 100, 101, 102, 103 -> exactly one valid pulse, after the 4th frame, value=101 (406>>2); no pulses after frames 1–3.
4. Clamp: MAX_VALUE=4000, AVG_LOG2=0, samples 4095 then 10 -> value=4000 with overrange=1, then value=10 with overrange=0.
5. Enable drop: AVG_LOG2=2, drop enable during frame 3 bit 7 -> frame 3 completes and no 4th frame starts. Re-enable and send four samples of 8 -> value=8; the 3 earlier samples are discarded.
6. Reset mid-frame: assert reset at SCLK rise 9 -> adc_cs_n and adc_sclk high without waiting for a clock edge, value=0. After release, a new full 16-bit frame returns a correct value.
